sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller.sv | 132 +++++++++++++
 tb/tb_sram_controller.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// Single-port asynchronous SRAM controller: IDLE -> ACCESS -> DONE handshake with registered strobes.
// Optional SRAM_CTRL_DEBUG_EN adds a 32-bit completed-transaction counter on dbg_count.
`timescale 1ns/1ps
module sram_controller #(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  input  logic [1:0]        req_be,
  output logic              rsp_valid,
  output logic [15:0]       rsp_rdata,
`ifdef SRAM_CTRL_DEBUG_EN
  output logic [31:0]       dbg_count,
`endif
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [15:0]       sram_dq,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic                wr_q;
  logic [15:0]         wdata_q;
  logic [1:0]          be_q;
  logic                dq_oe_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                ce_n_q, oe_n_q, we_n_q, ub_n_q, lb_n_q;
  logic                rsp_valid_q;
  logic [15:0]         rdata_q;
  logic [15:0]         rdata_d;
`ifdef SRAM_CTRL_DEBUG_EN
  logic [31:0]         dbg_q;
  assign dbg_count = dbg_q;
`endif

  // Disabled byte lanes read back as zero regardless of what the bus carries.
  always_comb begin
    rdata_d = '0;
    if (be_q[1]) rdata_d[15:8] = sram_dq[15:8];
    if (be_q[0]) rdata_d[7:0]  = sram_dq[7:0];
  end

  assign req_ready = (state_q == IDLE) && !reset;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign sram_addr = addr_q;
  assign sram_ce_n = ce_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;
  assign sram_ub_n = ub_n_q;
  assign sram_lb_n = lb_n_q;
  assign sram_dq   = dq_oe_q ? wdata_q : 'z;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      dq_oe_q     <= 1'b0;
      addr_q      <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
`ifdef SRAM_CTRL_DEBUG_EN
      dbg_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q <= ACCESS;
            cnt_q   <= '0;
            wr_q    <= req_write;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            addr_q  <= req_addr;
            dq_oe_q <= req_write;
            ce_n_q  <= 1'b0;
            oe_n_q  <= req_write;
            we_n_q  <= !req_write;
            ub_n_q  <= !req_be[1];
            lb_n_q  <= !req_be[0];
          end
        end
        ACCESS: begin
          if (cnt_q == LAST_CNT) begin
            state_q     <= DONE;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            rsp_valid_q <= 1'b1;
            if (!wr_q) rdata_q <= rdata_d;
`ifdef SRAM_CTRL_DEBUG_EN
            dbg_q       <= dbg_q + 32'd1;
`endif
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DONE: begin
          state_q     <= IDLE;
          ce_n_q      <= 1'b1;
          ub_n_q      <= 1'b1;
          lb_n_q      <= 1'b1;
          dq_oe_q     <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: vector table, scoreboard on rsp_valid, reset and back-to-back sequences.
`timescale 1ns/1ps
module tb_sram_controller;

  localparam int unsigned AW = 20;
  localparam int unsigned WC = 2;

  logic          CLOCK_50 = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [15:0]   req_wdata = '0;
  logic [1:0]    req_be = '0;
  logic          rsp_valid;
  logic [15:0]   rsp_rdata;
  logic [AW-1:0] sram_addr;
  wire  [15:0]   sram_dq;
  logic          sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
`ifdef SRAM_CTRL_DEBUG_EN
  logic [31:0]   dbg_count;
`endif

  sram_controller #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
`ifdef SRAM_CTRL_DEBUG_EN
    .dbg_count(dbg_count),
`endif
    .sram_addr(sram_addr), .sram_dq(sram_dq),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // SRAM model; when deselected the bus carries a marker so a stray controller driver is visible.
  logic [15:0] mem [0:(1<<AW)-1];
  assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr] :
                   (sram_ce_n ? 16'h5A5A : 'z);
  always @(posedge CLOCK_50) begin
    if (!sram_ce_n && !sram_we_n) begin
      if (!sram_ub_n) mem[sram_addr][15:8] <= sram_dq[15:8];
      if (!sram_lb_n) mem[sram_addr][7:0]  <= sram_dq[7:0];
    end
  end

  int n_pass = 0;
  int n_total = 0;
  logic [15:0] sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  wire [6:0] strobes = {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, req_ready, rsp_valid};

  always @(negedge CLOCK_50) begin
    if (rsp_valid) begin
      if (sb_q.size() == 0) check("unexpected_rsp_valid", 32'd1, 32'd0);
      else check("rsp_rdata", {16'h0, rsp_rdata}, {16'h0, sb_q.pop_front()});
    end
  end

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
    logic [1:0]    be;
    logic [15:0]   exp_rdata;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [AW-1:0] a, input logic [15:0] d,
                              input logic [1:0] be, input logic [15:0] e);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = d; v.be = be; v.exp_rdata = e;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    logic [6:0] exp_s;
    @(negedge CLOCK_50);
    check("ready_before_req", {31'h0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata; req_be = v.be;
    sb_q.push_back(v.exp_rdata);
    @(negedge CLOCK_50);
    // Garbage with valid high while busy must be ignored.
    req_write = ~v.wr; req_addr = ~v.addr; req_wdata = ~v.wdata; req_be = ~v.be;
    for (int k = 0; k < WC; k++) begin
      if (k > 0) @(negedge CLOCK_50);
      exp_s = {1'b0, v.wr, ~v.wr, ~v.be[1], ~v.be[0], 1'b0, 1'b0};
      check("access_strobes", {25'h0, strobes}, {25'h0, exp_s});
      check("access_addr", {12'h0, sram_addr}, {12'h0, v.addr});
      if (v.wr) check("access_dq", {16'h0, sram_dq}, {16'h0, v.wdata});
    end
    @(negedge CLOCK_50);
    req_valid = 1'b0;
    exp_s = {1'b0, 1'b1, 1'b1, ~v.be[1], ~v.be[0], 1'b0, 1'b1};
    check("done_strobes", {25'h0, strobes}, {25'h0, exp_s});
    check("done_addr", {12'h0, sram_addr}, {12'h0, v.addr});
    if (v.wr) check("done_dq", {16'h0, sram_dq}, {16'h0, v.wdata});
    @(negedge CLOCK_50);
    check("idle_strobes", {25'h0, strobes}, {25'h0, 7'b1111110});
    check("idle_dq_released", {16'h0, sram_dq}, {16'h0, 16'h5A5A});
  endtask

  vec_t vecs[12];
  int acc;
  int acc_cyc[3];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h0000;
    vecs[0]  = mk(1'b1, 20'h00012, 16'hBEEF, 2'b11, 16'h0000);
    vecs[1]  = mk(1'b0, 20'h00012, 16'h0000, 2'b11, 16'hBEEF);
    vecs[2]  = mk(1'b1, 20'h00012, 16'h1234, 2'b01, 16'hBEEF);
    vecs[3]  = mk(1'b0, 20'h00012, 16'h0000, 2'b11, 16'hBE34);
    vecs[4]  = mk(1'b0, 20'h00012, 16'h0000, 2'b10, 16'hBE00);
    vecs[5]  = mk(1'b1, 20'hFFFFF, 16'hA5C3, 2'b11, 16'hBE00);
    vecs[6]  = mk(1'b0, 20'hFFFFF, 16'h0000, 2'b11, 16'hA5C3);
    vecs[7]  = mk(1'b0, 20'hFFFFF, 16'h0000, 2'b00, 16'h0000);
    vecs[8]  = mk(1'b1, 20'h00012, 16'hFFFF, 2'b00, 16'h0000);
    vecs[9]  = mk(1'b0, 20'h00012, 16'h0000, 2'b11, 16'hBE34);
    vecs[10] = mk(1'b1, 20'h00001, 16'h7700, 2'b10, 16'hBE34);
    vecs[11] = mk(1'b0, 20'h00001, 16'h0000, 2'b11, 16'h7700);

    repeat (3) @(negedge CLOCK_50);
    check("reset_strobes", {25'h0, strobes}, {25'h0, 7'b1111100});
    check("reset_addr", {12'h0, sram_addr}, 32'h0);
    check("reset_rdata", {16'h0, rsp_rdata}, 32'h0);
    check("reset_dq", {16'h0, sram_dq}, {16'h0, 16'h5A5A});
    reset = 1'b0;
    #1 check("ready_after_reset", {31'h0, req_ready}, 32'd1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset during the second ACCESS cycle of a write.
    @(negedge CLOCK_50);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 20'h00055; req_wdata = 16'h1111; req_be = 2'b11;
    @(posedge CLOCK_50);
    #2 req_valid = 1'b0;
    @(posedge CLOCK_50);
    #3 reset = 1'b1;
    #1;
    check("midreset_strobes", {25'h0, strobes}, {25'h0, 7'b1111100});
    check("midreset_dq", {16'h0, sram_dq}, {16'h0, 16'h5A5A});
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;
    run_vec(mk(1'b0, 20'h00001, 16'h0000, 2'b11, 16'h7700));

    // Back-to-back reads with req_valid held high from the first edge after reset.
    @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 20'h00012; req_be = 2'b11;
    #1;
    acc = 0;
    for (int c = 0; c < 40 && acc < 3; c++) begin
      if (c > 0) @(negedge CLOCK_50);
      if (req_ready) begin
        acc_cyc[acc] = c;
        acc++;
        sb_q.push_back(16'hBE34);
      end
    end
    @(posedge CLOCK_50);
    #1 req_valid = 1'b0;
    check("b2b_accept_count", acc, 3);
    if (acc == 3) begin
      check("b2b_first_accept", acc_cyc[0], 0);
      check("b2b_second_accept", acc_cyc[1], 4);
      check("b2b_third_accept", acc_cyc[2], 8);
    end
    repeat (6) @(negedge CLOCK_50);
    check("scoreboard_drained", sb_q.size(), 0);
`ifdef SRAM_CTRL_DEBUG_EN
    check("dbg_count", dbg_count, 32'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
